pll_phase_ctrl: RTL and testbench

- Sequencer for the ECP5 EHXPLLL dynamic-phase and reset pins: pll_rst, PHASESEL, PHASEDIR, PHASESTEP and PHASELOADREG.
- Brings the PLL out of reset, waits for lock, then accepts step-phase commands from a host register interface.
- Issues correctly timed step pulses and tracks the current phase position of each PLL output.
- Runs in the stable PLL reference-clock domain (25 MHz board clock), never in a PLL output domain.

---
 rtl/pll_phase_ctrl_if.sv | 23 ++
 rtl/pll_phase_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_ctrl_if.sv
// Host command channel for the PLL phase sequencer.
//   cmd_valid/cmd_ready : request handshake, transfer when both high
//   cmd_sel/dir/steps   : channel, direction (1 = advance) and step count
//   cmd_done/cmd_err    : one-cycle completion pulse, err = aborted on lock loss
interface pll_phase_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_sel;
   logic       cmd_dir;
   logic [7:0] cmd_steps;
   logic       cmd_done;
   logic       cmd_err;

   modport master (
      output cmd_valid, cmd_sel, cmd_dir, cmd_steps,
      input  cmd_ready, cmd_done, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_dir, cmd_steps,
      output cmd_ready, cmd_done, cmd_err
   );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL reset / dynamic-phase sequencer, clocked from the stable
// reference clock. Releases the PLL from reset, waits for lock (with retry),
// then executes host step commands as timed PHASESTEP pulses while tracking
// the phase position of each of the four outputs.
//   clk, reset        : reference clock, synchronous active-high reset
//   pll_locked        : raw PLL LOCK (asynchronous)
//   pll_rst, phasesel, phasedir, phasestep_n, phaseloadreg_n : PLL pins
//   cmd               : host command channel (slave side)
//   pos_sel / pos_out : combinational position readback
//   ready, lost_lock, retries : status
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_RESET_PLL | pll_rst held high, counting RST_CYCLES
// S_WAIT_LOCK | waiting for synchronized lock, LOCK_TIMEOUT cycle budget
// S_IDLE      | locked, accepting commands
// S_SETUP     | PHASESEL/PHASEDIR settling before the first pulse
// S_PULSE     | phasestep_n low for PULSE_CYCLES
// S_GAP       | phasestep_n high for GAP_CYCLES after each pulse
module pll_phase_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int SETUP_CYCLES = 2,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int PHASE_MOD    = 48
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic [1:0] phasesel,
   output logic       phasedir,
   output logic       phasestep_n,
   output logic       phaseloadreg_n,
   pll_phase_ctrl_if.slave cmd,
   input  logic [1:0] pos_sel,
   output logic [7:0] pos_out,
   output logic       ready,
   output logic       lost_lock,
   output logic [7:0] retries
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int CMAX = imax(imax(imax(LOCK_TIMEOUT, RST_CYCLES), SETUP_CYCLES),
                              imax(PULSE_CYCLES, GAP_CYCLES));
   localparam int CW = $clog2(CMAX + 1);
   localparam int PW = $clog2(PHASE_MOD);

   // down-counter reload values; every timed state ends when the count hits 0
   localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] POS_MAX    = PW'(PHASE_MOD - 1);

   typedef enum logic [2:0] {
      S_RESET_PLL, S_WAIT_LOCK, S_IDLE, S_SETUP, S_PULSE, S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      steps_q, steps_d;
   logic [1:0]      sel_q;
   logic            dir_q;
   logic            done_q, done_d;
   logic            lk_meta, lk;
   logic [PW-1:0]   pos_q [4];
   logic [PW-1:0]   pos_cur, pos_next;
   logic            cnt_zero;
   logic            accept, step_now, lock_drop, timeout, abort;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      steps_d   = steps_q;
      done_d    = 1'b0;
      accept    = 1'b0;
      step_now  = 1'b0;
      lock_drop = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_zero) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = LOCK_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               state_d = S_IDLE;
            end else if (cnt_zero) begin
               state_d = S_RESET_PLL;
               cnt_d   = RST_LOAD;
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_IDLE: begin
            if (!lk) begin
               lock_drop = 1'b1;
            end else if (cmd.cmd_valid) begin
               accept  = 1'b1;
               steps_d = cmd.cmd_steps;
               if (cmd.cmd_steps == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  cnt_d   = SETUP_LOAD;
               end
            end
         end
         S_SETUP: begin
            if (!lk) begin
               lock_drop = 1'b1;
            end else if (cnt_zero) begin
               state_d = S_PULSE;
               cnt_d   = PULSE_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_PULSE: begin
            if (!lk) begin
               lock_drop = 1'b1;
            end else if (cnt_zero) begin
               state_d  = S_GAP;
               cnt_d    = GAP_LOAD;
               step_now = 1'b1;
               steps_d  = steps_q - 8'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_GAP: begin
            if (!lk) begin
               lock_drop = 1'b1;
            end else if (cnt_zero) begin
               if (steps_q != 8'd0) begin
                  state_d = S_PULSE;
                  cnt_d   = PULSE_LOAD;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = RST_LOAD;
         end
      endcase
      if (lock_drop) begin
         state_d = S_RESET_PLL;
         cnt_d   = RST_LOAD;
      end
   end

   assign pos_cur  = pos_q[sel_q];
   assign pos_next = dir_q ? ((pos_cur == POS_MAX) ? '0 : pos_cur + PW'(1))
                           : ((pos_cur == '0) ? POS_MAX : pos_cur - PW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= RST_LOAD;
         steps_q   <= '0;
         sel_q     <= '0;
         dir_q     <= 1'b0;
         done_q    <= 1'b0;
         lk_meta   <= 1'b0;
         lk        <= 1'b0;
         lost_lock <= 1'b0;
         retries   <= '0;
         for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
         done_q  <= done_d;
         lk_meta <= pll_locked;
         lk      <= lk_meta;
         if (accept) begin
            sel_q <= cmd.cmd_sel;
            dir_q <= cmd.cmd_dir;
         end
         if (timeout && retries != 8'hFF) retries <= retries + 8'd1;
         // a relocked PLL comes back at its static phase, so positions restart
         if (lock_drop) begin
            lost_lock <= 1'b1;
            for (int i = 0; i < 4; i++) pos_q[i] <= '0;
         end else if (step_now) begin
            pos_q[sel_q] <= pos_next;
         end
      end
   end

   // abort completion is reported in the cycle the loss is seen, not a cycle later
   assign abort = lock_drop && (state_q != S_IDLE);

   assign pll_rst        = (state_q == S_RESET_PLL);
   assign phasesel       = sel_q;
   assign phasedir       = dir_q;
   assign phasestep_n    = !((state_q == S_PULSE) && lk);
   assign phaseloadreg_n = 1'b1;
   assign ready          = (state_q == S_IDLE) && lk;
   assign cmd.cmd_ready  = (state_q == S_IDLE) && lk;
   assign cmd.cmd_done   = done_q || abort;
   assign cmd.cmd_err    = abort;
   assign pos_out        = 8'(pos_q[pos_sel]);

endmodule

// File: tb/tb_pll_phase_ctrl.sv
module tb_pll_phase_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep_n;
   logic       phaseloadreg_n;
   logic [1:0] pos_sel = 2'd0;
   logic [7:0] pos_out;
   logic       ready;
   logic       lost_lock;
   logic [7:0] retries;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pll_phase_ctrl_if cif();

   pll_phase_ctrl #(.LOCK_TIMEOUT(100)) dut (
      .clk            (clk),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .pll_rst        (pll_rst),
      .phasesel       (phasesel),
      .phasedir       (phasedir),
      .phasestep_n    (phasestep_n),
      .phaseloadreg_n (phaseloadreg_n),
      .cmd            (cif),
      .pos_sel        (pos_sel),
      .pos_out        (pos_out),
      .ready          (ready),
      .lost_lock      (lost_lock),
      .retries        (retries)
   );

   typedef struct { int cyc; bit err; } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [1:0] sel;
      logic       dir;
      logic [7:0] steps;
      logic [7:0] exp_pos;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // completion scoreboard: every accepted command has pushed its expected
   // completion cycle and error flag
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (cif.cmd_done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_err", int'(cif.cmd_err), int'(e.err));
         end
      end
   end

   task automatic issue(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                        input bit err, input int err_lat, output int acc);
      exp_t e;
      int n = 0;
      while (cif.cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("cmd_ready_wait", int'(cif.cmd_ready), 1);
      cif.cmd_valid = 1'b1;
      cif.cmd_sel   = sel;
      cif.cmd_dir   = dir;
      cif.cmd_steps = steps;
      acc = cyc;
      e.cyc = err ? acc + err_lat : ((steps == 8'd0) ? acc + 1 : acc + 3 + 8 * int'(steps));
      e.err = err;
      sb.push_back(e);
      tick();
      cif.cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int acc, n = 0, pulses = 0, bad = 0, lo = 0, hi = 0, selbad = 0;
      logic prev = 1'b1;
      bit seen = 0;
      issue(v.sel, v.dir, v.steps, 1'b0, 0, acc);
      while (!seen && n < 3000) begin
         if (cif.cmd_done === 1'b1) seen = 1;
         if (phasesel !== v.sel || phasedir !== v.dir) selbad++;
         if (phasestep_n === 1'b0) begin
            if (prev) begin
               pulses++;
               if (pulses > 1 && hi != 4) bad++;
               lo = 0;
            end
            lo++;
         end else begin
            if (!prev) begin
               if (lo != 4) bad++;
               hi = 0;
            end
            hi++;
         end
         prev = phasestep_n;
         if (!seen) begin
            tick();
            n++;
         end
      end
      chk($sformatf("vec%0d_done_seen", idx), int'(seen), 1);
      chk($sformatf("vec%0d_pulse_count", idx), pulses, int'(v.steps));
      chk($sformatf("vec%0d_pulse_shape_errs", idx), bad, 0);
      chk($sformatf("vec%0d_sel_dir_errs", idx), selbad, 0);
      pos_sel = v.sel;
      #1;
      chk($sformatf("vec%0d_pos", idx), int'(pos_out), int'(v.exp_pos));
   endtask

   initial begin
      int rst_bad, ret_bad, rdy_bad, rst_cnt, rdy_idx, acc, n;
      exp_t e;

      vt[0] = '{2'd1, 1'b1, 8'd3,  8'd3};
      vt[1] = '{2'd2, 1'b0, 8'd1,  8'd47};
      vt[2] = '{2'd2, 1'b1, 8'd49, 8'd0};
      vt[3] = '{2'd3, 1'b0, 8'd2,  8'd46};
      vt[4] = '{2'd0, 1'b1, 8'd5,  8'd5};

      cif.cmd_valid = 1'b0;
      cif.cmd_sel   = 2'd0;
      cif.cmd_dir   = 1'b0;
      cif.cmd_steps = 8'd0;
      repeat (3) tick();

      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_phasesel", int'(phasesel), 0);
      chk("rst_phasestep_n", int'(phasestep_n), 1);
      chk("rst_phaseloadreg_n", int'(phaseloadreg_n), 1);
      chk("rst_cmd_ready", int'(cif.cmd_ready), 0);
      chk("rst_cmd_done", int'(cif.cmd_done), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_lost_lock", int'(lost_lock), 0);
      chk("rst_retries", int'(retries), 0);
      chk("rst_pos", int'(pos_out), 0);

      // lock never arrives: 16 reset cycles + 100 wait cycles per attempt
      rst_bad = 0; ret_bad = 0; rdy_bad = 0;
      reset = 1'b0;
      for (int i = 0; i < 3 * 116 + 20; i++) begin
         if (pll_rst !== 1'((i % 116) < 16)) rst_bad++;
         if (retries !== 8'(i / 116)) ret_bad++;
         if (ready !== 1'b0) rdy_bad++;
         tick();
      end
      chk("nolock_pll_rst_errs", rst_bad, 0);
      chk("nolock_retries_errs", ret_bad, 0);
      chk("nolock_ready_errs", rdy_bad, 0);

      // lock arrives 30 cycles after reset release
      reset = 1'b1;
      repeat (3) tick();
      chk("rst2_retries", int'(retries), 0);
      reset = 1'b0;
      rst_cnt = 0;
      rdy_idx = -1;
      for (int i = 0; i < 40; i++) begin
         if (pll_rst === 1'b1) rst_cnt++;
         if (ready === 1'b1 && rdy_idx < 0) rdy_idx = i;
         if (i == 30) pll_locked = 1'b1;
         tick();
      end
      chk("lock_pll_rst_cycles", rst_cnt, 16);
      chk("lock_ready_latency_ok", int'(rdy_idx >= 32 && rdy_idx <= 33), 1);
      chk("lock_retries", int'(retries), 0);
      chk("lock_cmd_ready", int'(cif.cmd_ready), 1);

      for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

      // zero-step command immediately followed by a one-step command
      n = 0;
      while (cif.cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      cif.cmd_valid = 1'b1;
      cif.cmd_sel   = 2'd0;
      cif.cmd_dir   = 1'b1;
      cif.cmd_steps = 8'd0;
      acc = cyc;
      e.cyc = acc + 1; e.err = 1'b0;
      sb.push_back(e);
      tick();
      chk("b2b_ready_after_zero", int'(cif.cmd_ready), 1);
      chk("b2b_done_after_zero", int'(cif.cmd_done), 1);
      chk("b2b_no_pulse", int'(phasestep_n), 1);
      cif.cmd_sel   = 2'd1;
      cif.cmd_steps = 8'd1;
      e.cyc = cyc + 11; e.err = 1'b0;
      sb.push_back(e);
      tick();
      cif.cmd_valid = 1'b0;
      n = 0;
      while (cif.cmd_done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("b2b_second_done", int'(cif.cmd_done), 1);
      chk("b2b_phasesel", int'(phasesel), 1);
      pos_sel = 2'd1;
      #1;
      chk("b2b_pos1", int'(pos_out), 4);

      // lock lost during the second pulse of a five-step command
      issue(2'd1, 1'b0, 8'd5, 1'b1, 13, acc);
      while (cyc < acc + 11) tick();
      pll_locked = 1'b0;
      tick();
      chk("drop_pulse_still_low", int'(phasestep_n), 0);
      tick();
      chk("drop_phasestep_high", int'(phasestep_n), 1);
      chk("drop_cmd_done", int'(cif.cmd_done), 1);
      chk("drop_cmd_err", int'(cif.cmd_err), 1);
      tick();
      chk("drop_pll_rst", int'(pll_rst), 1);
      chk("drop_lost_lock", int'(lost_lock), 1);
      chk("drop_ready", int'(ready), 0);
      chk("drop_phasestep_idle", int'(phasestep_n), 1);
      for (int s = 0; s < 4; s++) begin
         pos_sel = 2'(s);
         #1;
         chk($sformatf("drop_pos%0d", s), int'(pos_out), 0);
      end
      repeat (5) tick();
      chk("drop_lost_lock_sticky", int'(lost_lock), 1);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
